rgb_fade_ctrl: RTL
==================

# rgb_fade_ctrl

Sequencer for the colour mixer's three 8-bit PWM channels. It accepts a target RGB colour through a valid/ready handshake and ramps the red, green and blue duty-cycle registers toward it in fixed steps. Duty values change only at 256-cycle frame boundaries, so the downstream PWM comparators never see a mid-period duty change. It sits between the colour-select logic and the three PWM instances, and drives their 8-bit duty inputs directly.

## Interface
- STEP, 1, duty increment per step, per channel; legal 1..255
- FRAMES_PER_STEP, 4, frames per step; legal 1..65535
- clk  in  1  system clock; shared with the PWM instances
- rst  in  1  synchronous, active-high reset
- tgt_valid  in  1  target colour offered
- tgt_ready  out  1  controller can accept a target
- tgt_r, tgt_g, tgt_b  in  8 each  target duty per channel
- duty_r, duty_g, duty_b  out  8 each  duty to the PWM inputs
- frame_tick  out  1  high for one cycle per 256-cycle frame
- busy  out  1  fade in progress
- done  out  1  one-cycle pulse when a fade completes

## Operation
- Frame counter: 8 bits, free-running, 0 after reset. frame_tick = (frame_cnt == 255).
- Step counter: 16 bits.
  - Cleared on target acceptance.
  - On each frame_tick in FADE: increments, or wraps to 0 when it equals FRAMES_PER_STEP-1.
- Step event = FADE && frame_tick && step_cnt == FRAMES_PER_STEP-1.
- States:
  - IDLE
    - tgt_ready=1, busy=0.
    - tgt_valid && tgt_ready → latch tgt_r/g/b, clear step_cnt, go to FADE.
  - FADE
    - tgt_ready=0, busy=1. tgt_valid is ignored; targets are not re-latched.
    - On each step event, for every channel: if lin<tgt, lin += min(STEP, tgt-lin); if lin>tgt, lin -= min(STEP, lin-tgt); if equal, no change.
    - Arithmetic is 9-bit internally. Results never overshoot the target and never wrap.
    - If all three channels equal their targets after the update (or were already equal), go to IDLE and pulse done.
- lin registers change only on step events, so the duty outputs change only on the edge where frame_cnt wraps 255→0.
- Reset values: lin=0, duty_*=0, state IDLE, tgt_ready=0 during rst and 1 from the first cycle after, busy=0, done=0, frame_tick=0, frame_cnt=0, step_cnt=0.
- Reset mid-fade abandons the fade: duty outputs return to 0, done is not pulsed.

## Timing
- Handshake transfer occurs on any rising edge with tgt_valid && tgt_ready. busy rises on the next cycle.
- Without gamma, duty_* equals lin with zero added latency: it is registered and updates on the step-event edge.
- Completion:
  - done goes high in the cycle after the final step event.
  - busy goes low and tgt_ready goes high in that same cycle.
  - A new target may be accepted in that cycle.
- Steps needed per channel = ceil(|tgt-lin|/STEP). The fade takes the channel maximum of these, with FRAMES_PER_STEP×256 cycles per step.
  - The first step event falls on the FRAMES_PER_STEP-th frame_tick after acceptance.
- A target equal to the current colour completes at the first step event, with no duty change.

## Configuration
- RGB_FADE_GAMMA_EN
  - Defined: each output is registered as duty_x = (lin_x*lin_x + 255) >> 8 (16-bit product). This adds exactly one cycle of latency after lin changes, and done is delayed by one cycle to match. Maps 0→0, 1→1, 128→64, 255→255.
  - Undefined: duty_x = lin_x, with no multiplier and no extra cycle.

## Test plan
- Reset: hold rst 3 cycles with tgt_valid=1 → all duty_*=0, busy=0, done=0, tgt_ready=0 during rst, and no target latched.
- STEP=1, FRAMES_PER_STEP=1, target (10,0,0) from (0,0,0) → duty_r steps 0,1,…,10, one step per frame_tick, changing only at the 255→0 wrap. done pulses once after the 10th step; duty_g=duty_b=0 throughout.
- STEP=4, target (10,255,3) from 0 → red 4,8,10; green reaches 252 after 63 steps and 255 at step 64; blue reaches 3 at step 1. done follows step 64, with no overshoot.
- Down-fade, STEP=7, from (20,20,20) to (0,20,6) → red 13,6,0; blue 13,6; green constant. done follows step 3.
- Target (5,5,5) offered while in FADE → tgt_ready=0, the value is ignored, and the fade completes to the original target. Asserting rst mid-fade → duties 0 on the next cycle, no done.
- With RGB_FADE_GAMMA_EN, fade to (128,255,1) → final duty (64,255,1), and done occurs one cycle later than in the non-gamma build.

Source files
------------

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl
// Ramps three 8-bit PWM duty registers toward a target colour in fixed
// steps. Duty values change only on the edge where the free-running 8-bit
// frame counter wraps 255->0, so downstream PWM comparators never see a
// mid-period change.
//
// Parameters:
//   STEP             duty increment per step, per channel (1..255)
//   FRAMES_PER_STEP  256-cycle frames per step (1..65535)
//
// Ports:
//   clk                  system clock (shared with the PWM instances)
//   rst                  synchronous, active-high reset
//   tgt_valid/tgt_ready  target colour handshake
//   tgt_r/g/b            target duty per channel
//   duty_r/g/b           duty to the PWM inputs
//   frame_tick           high for one cycle per 256-cycle frame
//   busy                 fade in progress
//   done                 one-cycle pulse when a fade completes
//
// Build option:
//   RGB_FADE_GAMMA_EN    when defined, each duty output is registered as
//                        (lin*lin + 255) >> 8, adding one cycle of latency;
//                        done is delayed by one cycle to stay aligned.
module rgb_fade_ctrl #(
  parameter int unsigned STEP            = 1,
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, FADE} state_t;

  localparam logic [8:0]  STEP9  = 9'(STEP);
  localparam logic [15:0] FPS_M1 = 16'(FRAMES_PER_STEP - 1);

  state_t      state;
  logic [7:0]  frame_cnt;
  logic [15:0] step_cnt;
  logic [7:0]  lin_r, lin_g, lin_b;
  logic [7:0]  tr, tg, tb;
  logic [7:0]  nxt_r, nxt_g, nxt_b;
  logic        step_evt;
  logic        all_eq;
  logic        done_i;

  // Move one channel toward its target by at most STEP, never past it.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    logic [8:0] c9, t9, d9;
    c9 = {1'b0, cur};
    t9 = {1'b0, tgt};
    if (t9 > c9) begin
      d9 = t9 - c9;
      return 8'(c9 + ((d9 < STEP9) ? d9 : STEP9));
    end else if (c9 > t9) begin
      d9 = c9 - t9;
      return 8'(c9 - ((d9 < STEP9) ? d9 : STEP9));
    end else begin
      return cur;
    end
  endfunction

  assign frame_tick = (frame_cnt == 8'hFF);
  assign step_evt   = (state == FADE) && frame_tick && (step_cnt == FPS_M1);

  assign nxt_r  = step_toward(lin_r, tr);
  assign nxt_g  = step_toward(lin_g, tg);
  assign nxt_b  = step_toward(lin_b, tb);
  assign all_eq = (nxt_r == tr) && (nxt_g == tg) && (nxt_b == tb);

  // Held low while rst is asserted so nothing is accepted during reset.
  assign tgt_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      step_cnt  <= '0;
      lin_r     <= '0;
      lin_g     <= '0;
      lin_b     <= '0;
      tr        <= '0;
      tg        <= '0;
      tb        <= '0;
      busy      <= 1'b0;
      done_i    <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt + 8'd1;
      done_i    <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tr       <= tgt_r;
            tg       <= tgt_g;
            tb       <= tgt_b;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= FADE;
          end
        end
        FADE: begin
          if (frame_tick) begin
            step_cnt <= (step_cnt == FPS_M1) ? '0 : step_cnt + 16'd1;
          end
          if (step_evt) begin
            lin_r <= nxt_r;
            lin_g <= nxt_g;
            lin_b <= nxt_b;
            if (all_eq) begin
              busy   <= 1'b0;
              done_i <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  function automatic logic [7:0] gamma(input logic [7:0] x);
    return 8'((({8'b0, x} * {8'b0, x}) + 16'd255) >> 8);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r <= '0;
      duty_g <= '0;
      duty_b <= '0;
      done   <= 1'b0;
    end else begin
      duty_r <= gamma(lin_r);
      duty_g <= gamma(lin_g);
      duty_b <= gamma(lin_b);
      done   <= done_i;
    end
  end
`else
  assign duty_r = lin_r;
  assign duty_g = lin_g;
  assign duty_b = lin_b;
  assign done   = done_i;
`endif

endmodule
